// File: rtl/pos_pid_mc.sv
// Time-multiplexed multi-channel position PID for galvo axes.
// One shared datapath walks the channels in turn (ERR -> MUL -> SUM -> LIM per
// channel). All DAC outputs are then published together on a single dac_valid
// pulse, so downstream writers always see a coherent set of axis codes.
module pos_pid_mc #(
  parameter int NCH     = 2,
  parameter int DW      = 16,
  parameter int CW      = 16,
  parameter int AW      = 48,
  parameter int P_SHIFT = 10,
  parameter int I_SHIFT = 10,
  parameter int D_SHIFT = 6
) (
  input  logic              sys_rstn,
  input  logic              clk_pid,
  input  logic              sample_valid,
  input  logic [NCH*DW-1:0] pos_target,
  input  logic [NCH*DW-1:0] pos_adc,
  input  logic [NCH*CW-1:0] kp,
  input  logic [NCH*CW-1:0] ki,
  input  logic [NCH*CW-1:0] kd,
  input  logic [NCH-1:0]    ch_enable,
  input  logic [NCH-1:0]    pid_sign,
  input  logic [DW-2:0]     dac_limit,
  input  logic [AW-2:0]     i_sat,
  output logic [NCH*DW-1:0] pos_dac,
  output logic              dac_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
  localparam logic [DW-1:0]  MID     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, LIM, DONE} state_t;

  state_t state, next_state;
  logic [CHW-1:0] ch;

  // Per-pass snapshot of all channel inputs; held constant for the whole pass.
  logic [NCH*DW-1:0] tgt_q, adc_q;
  logic [NCH*CW-1:0] kp_q, ki_q, kd_q;
  logic [NCH-1:0]    en_q, sign_q;

  // Per-channel persistent state.
  logic signed [AW-1:0] integ    [NCH];
  logic signed [AW-1:0] err_last [NCH];
  logic [NCH-1:0]       d_valid;
  logic [DW-1:0]        shadow   [NCH];

  // Pipeline registers of the shared datapath.
  logic signed [AW-1:0] err_q, integ_new_q, delta_q;
  logic signed [AW-1:0] p_q, i_q, d_q, pid_q;

  // Current-channel views of the snapshot.
  logic [DW-1:0]        cur_tgt, cur_adc;
  logic signed [AW-1:0] kp_s, ki_s, kd_s;

  assign cur_tgt = tgt_q[ch*DW +: DW];
  assign cur_adc = adc_q[ch*DW +: DW];
  assign kp_s    = $signed({{(AW-CW){1'b0}}, kp_q[ch*CW +: CW]});
  assign ki_s    = $signed({{(AW-CW){1'b0}}, ki_q[ch*CW +: CW]});
  assign kd_s    = $signed({{(AW-CW){1'b0}}, kd_q[ch*CW +: CW]});

  // Error, clamped integrator candidate and guarded derivative delta.
  logic signed [DW:0]   err_n;
  logic signed [AW-1:0] err_ext, integ_sum, integ_clamp, delta_n, isat_s;
  logic signed [AW-1:0] p_full, i_full, d_full, pid_sum, lim_s;

  assign err_n   = $signed({1'b0, cur_tgt}) - $signed({1'b0, cur_adc});
  assign err_ext = {{(AW-DW-1){err_n[DW]}}, err_n};
  assign isat_s  = $signed({1'b0, i_sat});
  assign lim_s   = $signed({{(AW-DW+1){1'b0}}, dac_limit});
  assign integ_sum = integ[ch] + err_ext;
  assign delta_n   = d_valid[ch] ? (err_ext - err_last[ch]) : '0;

  // Saturating integrator clamp to [-i_sat, +i_sat].
  always_comb begin
    // NOTE: combinational blocks assign a default first so no path leaves the
    // output unassigned, which would otherwise infer a latch.
    integ_clamp = integ_sum;
    if (integ_sum > isat_s)       integ_clamp = isat_s;
    else if (integ_sum < -isat_s) integ_clamp = -isat_s;
  end

  assign p_full  = (kp_s * err_q) >>> P_SHIFT;
  assign i_full  = (ki_s * integ_new_q) >>> I_SHIFT;
  assign d_full  = (kd_s * delta_q) >>> D_SHIFT;
  assign pid_sum = p_q + i_q + d_q;

  assign busy = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!sys_rstn) state <= IDLE;
    else           state <= next_state;
  end

  // FSM next-state: one pass visits ERR/MUL/SUM/LIM once per channel.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid) next_state = ERR;
      ERR:     next_state = MUL;
      MUL:     next_state = SUM;
      SUM:     next_state = LIM;
      LIM:     next_state = (ch == LAST_CH) ? DONE : ERR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath, per-channel state and output publication.
  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    if (!sys_rstn) begin
      ch          <= '0;
      tgt_q       <= '0;
      adc_q       <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      en_q        <= '0;
      sign_q      <= '0;
      err_q       <= '0;
      integ_new_q <= '0;
      delta_q     <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      pid_q       <= '0;
      d_valid     <= '0;
      dac_valid   <= 1'b0;
      overrun     <= 1'b0;
      pos_dac     <= {NCH{MID}};
      // NOTE: these small per-channel arrays are register files, not RAM, and
      // must start cleared, so they are reset along with the other state.
      for (int k = 0; k < NCH; k++) begin
        integ[k]    <= '0;
        err_last[k] <= '0;
        shadow[k]   <= MID;
      end
    end else begin
      dac_valid <= 1'b0;
      overrun   <= sample_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_valid) begin
            tgt_q  <= pos_target;
            adc_q  <= pos_adc;
            kp_q   <= kp;
            ki_q   <= ki;
            kd_q   <= kd;
            en_q   <= ch_enable;
            sign_q <= pid_sign;
            ch     <= '0;
          end
        end
        ERR: begin
          err_q       <= err_ext;
          integ_new_q <= integ_clamp;
          delta_q     <= delta_n;
        end
        MUL: begin
          p_q <= p_full;
          i_q <= i_full;
          d_q <= d_full;
        end
        SUM: begin
          pid_q         <= sign_q[ch] ? -pid_sum : pid_sum;
          integ[ch]     <= integ_new_q;
          err_last[ch]  <= err_q;
          d_valid[ch]   <= 1'b1;
        end
        LIM: begin
          if (!en_q[ch]) begin
            // A disabled channel parks at midscale and forgets its history.
            shadow[ch]   <= MID;
            integ[ch]    <= '0;
            err_last[ch] <= '0;
            d_valid[ch]  <= 1'b0;
          end else if (pid_q > lim_s) begin
            shadow[ch] <= MID + {1'b0, dac_limit};
          end else if (pid_q < -lim_s) begin
            shadow[ch] <= MID - {1'b0, dac_limit};
          end else begin
            shadow[ch] <= MID + pid_q[DW-1:0];
          end
          if (ch != LAST_CH) ch <= ch + 1'b1;
        end
        DONE: begin
          for (int k = 0; k < NCH; k++) pos_dac[k*DW +: DW] <= shadow[k];
          dac_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_pid_mc.sv
// Directed bench for pos_pid_mc at default parameters (NCH=2, DW=16).
module tb_pos_pid_mc;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int AW  = 48;

  logic              sys_rstn;
  logic              clk_pid;
  logic              sample_valid;
  logic [NCH*DW-1:0] pos_target, pos_adc;
  logic [NCH*CW-1:0] kp, ki, kd;
  logic [NCH-1:0]    ch_enable, pid_sign;
  logic [DW-2:0]     dac_limit;
  logic [AW-2:0]     i_sat;
  logic [NCH*DW-1:0] pos_dac;
  logic              dac_valid, busy, overrun;

  int passes = 0;
  int total  = 0;

  pos_pid_mc dut (
    .sys_rstn    (sys_rstn),
    .clk_pid     (clk_pid),
    .sample_valid(sample_valid),
    .pos_target  (pos_target),
    .pos_adc     (pos_adc),
    .kp          (kp),
    .ki          (ki),
    .kd          (kd),
    .ch_enable   (ch_enable),
    .pid_sign    (pid_sign),
    .dac_limit   (dac_limit),
    .i_sat       (i_sat),
    .pos_dac     (pos_dac),
    .dac_valid   (dac_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk_pid = 1'b0;
  always #5 clk_pid = ~clk_pid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk_pid);
    sys_rstn = 1'b0;
    repeat (2) @(negedge clk_pid);
    sys_rstn = 1'b1;
  endtask

  // Strobe one sample for ch0 (ch1 gets midscale inputs) and report the number
  // of clock edges from acceptance to dac_valid, or -1 if it never arrives.
  task automatic run_sample(input logic [DW-1:0] tgt0, input logic [DW-1:0] adc0,
                            output int lat);
    @(negedge clk_pid);
    pos_target   = {16'd32768, tgt0};
    pos_adc      = {16'd32768, adc0};
    sample_valid = 1'b1;
    @(posedge clk_pid);
    #1 sample_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk_pid);
      #1;
      if (dac_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat;
  int nvalid;

  initial begin
    sys_rstn     = 1'b0;
    sample_valid = 1'b0;
    pos_target   = {NCH{16'd32768}};
    pos_adc      = {NCH{16'd32768}};
    kp = '0; ki = '0; kd = '0;
    ch_enable = 2'b01;
    pid_sign  = 2'b00;
    dac_limit = 15'd1000;
    i_sat     = 47'd1000000;
    repeat (3) @(negedge clk_pid);
    sys_rstn = 1'b1;
    @(posedge clk_pid); #1;

    // Reset state.
    check("rst_dac0",    pos_dac[15:0],  64'd32768);
    check("rst_dac1",    pos_dac[31:16], 64'd32768);
    check("rst_valid",   dac_valid,      64'd0);
    check("rst_busy",    busy,           64'd0);
    check("rst_overrun", overrun,        64'd0);

    // P-only, ch0; ch1 disabled.
    kp = {16'd0, 16'd1024};
    run_sample(16'd33000, 16'd32768, lat);
    check("p_latency", lat,            64'd9);
    check("p_dac0",    pos_dac[15:0],  64'd33000);
    check("p_dac1",    pos_dac[31:16], 64'd32768);
    check("p_busy",    busy,           64'd0);
    @(posedge clk_pid); #1;
    check("p_valid_pulse", dac_valid,  64'd0);

    // Sign inversion.
    pid_sign = 2'b01;
    run_sample(16'd33000, 16'd32768, lat);
    check("sign_dac0", pos_dac[15:0], 64'd32536);
    pid_sign = 2'b00;

    // Output limit, both directions.
    dac_limit = 15'd100;
    run_sample(16'd33000, 16'd32768, lat);
    check("lim_hi_dac0", pos_dac[15:0], 64'd32868);
    run_sample(16'd32768, 16'd33000, lat);
    check("lim_lo_dac0", pos_dac[15:0], 64'd32668);

    // Integrator clamp: I-only, error 232, i_sat 500.
    do_reset();
    kp = '0; ki = {16'd0, 16'd1024}; kd = '0;
    dac_limit = 15'd1000;
    i_sat = 47'd500;
    run_sample(16'd33000, 16'd32768, lat);
    check("int_1", pos_dac[15:0], 64'd33000);
    run_sample(16'd33000, 16'd32768, lat);
    check("int_2", pos_dac[15:0], 64'd33232);
    run_sample(16'd33000, 16'd32768, lat);
    check("int_3", pos_dac[15:0], 64'd33268);
    run_sample(16'd33000, 16'd32768, lat);
    check("int_4", pos_dac[15:0], 64'd33268);

    // Derivative first-sample guard.
    do_reset();
    kp = '0; ki = '0; kd = {16'd0, 16'd64};
    i_sat = 47'd1000000;
    run_sample(16'd32868, 16'd32768, lat);
    check("d_first",  pos_dac[15:0], 64'd32768);
    run_sample(16'd33068, 16'd32768, lat);
    check("d_second", pos_dac[15:0], 64'd32968);
    ch_enable = 2'b00;
    run_sample(16'd33068, 16'd32768, lat);
    check("d_disabled", pos_dac[15:0], 64'd32768);
    ch_enable = 2'b01;
    run_sample(16'd33068, 16'd32768, lat);
    check("d_reenable", pos_dac[15:0], 64'd32768);
    run_sample(16'd33268, 16'd32768, lat);
    check("d_rearmed", pos_dac[15:0], 64'd32968);

    // Overrun: second strobe three cycles into the pass.
    do_reset();
    kp = {16'd0, 16'd1024}; ki = '0; kd = '0;
    @(negedge clk_pid);
    pos_target   = {16'd32768, 16'd33000};
    pos_adc      = {NCH{16'd32768}};
    sample_valid = 1'b1;
    @(posedge clk_pid);
    #1 sample_valid = 1'b0;
    check("ovr_busy", busy, 64'd1);
    repeat (2) @(posedge clk_pid);
    @(negedge clk_pid);
    pos_target   = {16'd32768, 16'd32000};
    sample_valid = 1'b1;
    @(posedge clk_pid);
    #1 sample_valid = 1'b0;
    check("ovr_pulse", overrun, 64'd1);
    @(posedge clk_pid); #1;
    check("ovr_clear", overrun, 64'd0);
    nvalid = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk_pid); #1;
      if (dac_valid) nvalid++;
    end
    check("ovr_nvalid", nvalid, 64'd1);
    check("ovr_dac0",   pos_dac[15:0], 64'd33000);

    // Reset in mid-pass abandons it.
    @(negedge clk_pid);
    pos_target   = {16'd32768, 16'd33100};
    sample_valid = 1'b1;
    @(posedge clk_pid);
    #1 sample_valid = 1'b0;
    repeat (4) @(posedge clk_pid);
    #1 sys_rstn = 1'b0;
    #1;
    check("mrst_dac0", pos_dac[15:0], 64'd32768);
    check("mrst_busy", busy,          64'd0);
    @(negedge clk_pid);
    sys_rstn = 1'b1;
    nvalid = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk_pid); #1;
      if (dac_valid) nvalid++;
    end
    check("mrst_nvalid", nvalid,        64'd0);
    check("mrst_dac0_after", pos_dac[15:0], 64'd32768);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
